alu_serial_seq: RTL and testbench

- Bit-serial sequencer that drives one external 1-bit ALU slice (a, b, less, a-invert, b-invert, carry-in, op[1:0] -> result, set, ovf) over WIDTH cycles to compute a WIDTH-bit operation.
- Holds the ripple carry between cycles and assembles the result word.
- Provides a start/done handshake to the pipeline control logic.
- Lets the pipeline use a single small ALU slice for multi-cycle execute operations.

---
 rtl/alu_serial_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_serial_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer for a single external 1-bit ALU slice.
// It walks the operands LSB first, one bit per cycle. It keeps the ripple carry
// itself because the slice has no carry-out port, and it builds the result word.
// A FIX cycle re-drives bit 0 so that SLT can feed the MSB set bit into less.
// Optional build macro: ALU_SEQ_FIX_SKIP_EN. When it is defined, only SLT goes
// through FIX; every other op goes from RUN straight to DONE.
module alu_serial_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             slc_a,
  output logic             slc_b,
  output logic             slc_less,
  output logic             slc_ainv,
  output logic             slc_binv,
  output logic             slc_cin,
  output logic [1:0]       slc_op,
  input  logic             slc_result,
  input  logic             slc_set,
  input  logic             slc_ovf,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_ctl;
  logic [CNT_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_set;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_done;

  logic               w_ainv;
  logic               w_bneg;
  logic [1:0]         w_op;
  logic               w_is_slt;
  logic               w_last;
  logic               w_abit;
  logic               w_bbit;
  logic               w_ax;
  logic               w_bx;
  logic               w_carry_nxt;
  logic               w_goto_fix;
  logic [WIDTH-1:0]   w_res_nxt;

  assign w_ainv   = r_ctl[3];
  assign w_bneg   = r_ctl[2];
  assign w_op     = r_ctl[1:0];
  assign w_is_slt = (w_op == 2'b11);
  assign w_last   = (r_idx == CNT_W'(WIDTH - 1));
  assign w_abit   = r_a[r_idx];
  assign w_bbit   = r_b[r_idx];

  // The ripple carry is tracked here from the operand bits after inversion.
  assign w_ax        = w_abit ^ w_ainv;
  assign w_bx        = w_bbit ^ w_bneg;
  assign w_carry_nxt = (w_ax & w_bx) | (w_ax & r_carry) | (w_bx & r_carry);

`ifdef ALU_SEQ_FIX_SKIP_EN
  // Only SLT needs the bit-0 re-drive, so the other ops skip FIX.
  assign w_goto_fix = w_is_slt;
`else
  assign w_goto_fix = 1'b1;
`endif

  assign ready    = (r_state == S_IDLE);
  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_ovf;
  assign done     = r_done;

  // Result word after this cycle's slice bit is merged in. It also feeds the zero flag.
  always_comb begin
    w_res_nxt = r_result;
    case (r_state)
      S_RUN:   w_res_nxt[r_idx] = slc_result;
      S_FIX:   if (w_is_slt) w_res_nxt[0] = slc_result;
      default: w_res_nxt = r_result;
    endcase
  end

  // Slice inputs are decoded from the state. They are held at 0 in IDLE and DONE.
  always_comb begin
    slc_a    = 1'b0;
    slc_b    = 1'b0;
    slc_less = 1'b0;
    slc_ainv = 1'b0;
    slc_binv = 1'b0;
    slc_cin  = 1'b0;
    slc_op   = 2'b00;
    case (r_state)
      S_RUN: begin
        slc_a    = w_abit;
        slc_b    = w_bbit;
        slc_ainv = w_ainv;
        slc_binv = w_bneg;
        slc_op   = w_op;
        slc_cin  = r_carry;
      end
      S_FIX: begin
        slc_a    = r_a[0];
        slc_b    = r_b[0];
        slc_ainv = w_ainv;
        slc_binv = w_bneg;
        slc_op   = w_op;
        slc_cin  = w_bneg;
        slc_less = r_set;
      end
      default: ;
    endcase
  end

  // Sequencer FSM: accept, run WIDTH bits, optional SLT fix-up, then pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_ctl    <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_set    <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_ctl    <= alu_ctl;
            r_idx    <= '0;
            r_carry  <= alu_ctl[2];
            r_set    <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_result <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= w_res_nxt;
          r_carry  <= w_carry_nxt;
          r_idx    <= r_idx + CNT_W'(1);
          if (w_last) begin
            r_set <= slc_set;
            r_ovf <= (w_op == 2'b10) ? slc_ovf : 1'b0;
            if (w_goto_fix) begin
              r_state <= S_FIX;
            end else begin
              r_zero  <= (w_res_nxt == '0);
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_FIX: begin
          r_result <= w_res_nxt;
          r_zero   <= (w_res_nxt == '0);
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed testbench for alu_serial_seq with WIDTH=8.
// It includes a behavioural model of the external 1-bit ALU slice.
module tb_alu_serial_seq;

  localparam int W = 8;
`ifdef ALU_SEQ_FIX_SKIP_EN
  localparam int LAT_NF = 9;
`else
  localparam int LAT_NF = 10;
`endif
  localparam int LAT_SLT = 10;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         ready;
  logic [3:0]   alu_ctl;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         slc_a, slc_b, slc_less, slc_ainv, slc_binv, slc_cin;
  logic [1:0]   slc_op;
  logic         slc_result, slc_set, slc_ovf;
  logic [W-1:0] result;
  logic         zero, overflow, done;

  int n_assert = 0;
  int n_fail   = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .alu_ctl(alu_ctl),
    .a_in(a_in), .b_in(b_in), .slc_a(slc_a), .slc_b(slc_b), .slc_less(slc_less),
    .slc_ainv(slc_ainv), .slc_binv(slc_binv), .slc_cin(slc_cin), .slc_op(slc_op),
    .slc_result(slc_result), .slc_set(slc_set), .slc_ovf(slc_ovf),
    .result(result), .zero(zero), .overflow(overflow), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Classic 1-bit ALU slice: invertible inputs, AND/OR/ADD/LESS mux, set = sum, ovf at MSB.
  logic m_ax, m_bx, m_sum, m_cout;
  always_comb begin
    m_ax   = slc_a ^ slc_ainv;
    m_bx   = slc_b ^ slc_binv;
    m_sum  = m_ax ^ m_bx ^ slc_cin;
    m_cout = (m_ax & m_bx) | (m_ax & slc_cin) | (m_bx & slc_cin);
    case (slc_op)
      2'b00:   slc_result = m_ax & m_bx;
      2'b01:   slc_result = m_ax | m_bx;
      2'b10:   slc_result = m_sum;
      default: slc_result = slc_less;
    endcase
    slc_set = m_sum;
    slc_ovf = slc_cin ^ m_cout;
  end

  function automatic logic [7:0] slc_pack();
    return {slc_less, slc_ainv, slc_binv, slc_cin, slc_op, slc_a, slc_b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check its latency, result flags and the cycle after done.
  // pulse>0 raises start with different operands during RUN at that cycle count.
  task automatic do_op(input string tag, input logic [3:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                       input logic eo, input int lat, input int pulse);
    int cnt;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(ready), 32'd1);
    alu_ctl = ctl; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1)
        chk({tag, ".bit0"}, 32'({slc_a, slc_b, slc_cin}), 32'({a[0], b[0], ctl[2]}));
      if (pulse != 0 && cnt == pulse) begin
        start = 1'b1; a_in = ~a; b_in = 8'h55; alu_ctl = C_OR;
      end
      if (pulse != 0 && cnt == pulse + 1) start = 1'b0;
    end while (!done && cnt < 40);
    chk({tag, ".lat"}, 32'(cnt), 32'(lat));
    chk({tag, ".result"}, 32'(result), 32'(er));
    chk({tag, ".zero"}, 32'(zero), 32'(ez));
    chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
    @(negedge clk);
    chk({tag, ".post"}, 32'({done, ready, slc_pack()}), 32'({1'b0, 1'b1, 8'h00}));
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; alu_ctl = '0; a_in = '0; b_in = '0;
    #1;
    chk("rst.async", 32'({ready, done, zero, overflow, result, slc_pack()}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}));
    repeat (2) @(negedge clk);
    chk("rst.state", 32'({ready, done, zero, overflow, result, slc_pack()}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}));
    rst_n = 1'b1;

    do_op("add",   C_ADD, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, LAT_NF, 0);
    do_op("sub_v", C_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, LAT_NF, 0);
    do_op("sub_z", C_SUB, 8'h25, 8'h25, 8'h00, 1'b1, 1'b0, LAT_NF, 0);
    do_op("slt1",  C_SLT, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, LAT_SLT, 0);
    do_op("slt0",  C_SLT, 8'h05, 8'h03, 8'h00, 1'b1, 1'b0, LAT_SLT, 0);
    do_op("sltn",  C_SLT, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, LAT_SLT, 0);
    do_op("and",   C_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, LAT_NF, 0);
    do_op("or",    C_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, LAT_NF, 0);
    do_op("nor",   C_NOR, 8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0, LAT_NF, 0);
    do_op("ignst", C_ADD, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, LAT_NF, 3);

    // Keep start high through done. The second op must be accepted the cycle after done.
    @(negedge clk);
    alu_ctl = C_ADD; a_in = 8'h01; b_in = 8'h02; start = 1'b1;
    @(posedge clk);
    #1 a_in = 8'h10; b_in = 8'h20;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!done && cnt < 40);
    chk("hold.lat1", 32'(cnt), 32'(LAT_NF));
    chk("hold.res1", 32'(result), 32'h03);
    @(negedge clk);
    cnt++;
    chk("hold.idle", 32'({ready, done}), 32'({1'b1, 1'b0}));
    @(negedge clk);
    cnt++;
    start = 1'b0;
    chk("hold.acc", 32'(ready), 32'd0);
    do begin
      @(negedge clk);
      cnt++;
    end while (!done && cnt < 80);
    chk("hold.lat2", 32'(cnt), 32'(2 * LAT_NF + 1));
    chk("hold.res2", 32'(result), 32'h30);
    @(negedge clk);

    // Assert reset asynchronously while bit 4 of an ADD is in progress.
    @(negedge clk);
    alu_ctl = C_ADD; a_in = 8'h1F; b_in = 8'h00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid.prefix", 32'({result, slc_a}), 32'({8'h0F, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("mid.rst", 32'({ready, done, zero, overflow, result, slc_pack()}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op("postrst", C_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, LAT_NF, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
